reg_file_seq: RTL and testbench

- Initiator-side access sequencer for the single-port register file (one 5-bit address, one 16-bit write-data input, one write strobe, one combinational read-data output).
- Accepts one decode-stage request (rs1, rs2, rd, wdata, we) through a valid/ready handshake.
- Time-multiplexes the single port to read both source registers, then optionally writes rd.
- Returns both operands to the pipeline through a valid/ready response.

---
 rtl/reg_file_seq.sv | 169 ++++++++++++++++
 tb/tb_reg_file_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_seq.sv
// Access sequencer that time-multiplexes one single-port register file: read rs1, read rs2, then optionally write rd.
// Optional build macro RF_ZERO_REG_EN: register 0 reads as zero and is never written.
module reg_file_seq #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_op1,
  output logic [DATA_W-1:0] rsp_op2,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   rs1_r;
  logic [ADDR_W-1:0]   rs2_r;
  logic [ADDR_W-1:0]   rd_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic [DATA_W-1:0]   op1_r;
  logic [DATA_W-1:0]   op2_r;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic [ADDR_W-1:0]   rf_addr_r;
  logic [DATA_W-1:0]   rf_wdata_r;
  logic                rf_write_r;
  logic [ADDR_W-1:0]   rf_addr_s;
  logic [DATA_W-1:0]   rf_wdata_s;
  logic                rf_write_s;
  logic                write_needed_s;
  logic                rs1_zero_s;
  logic                rs2_zero_s;

  // Decide whether the captured request needs a write slot and which reads are forced to zero.
  always_comb begin
`ifdef RF_ZERO_REG_EN
    write_needed_s = we_r && (rd_r != {ADDR_W{1'b0}});
    rs1_zero_s     = (rs1_r == {ADDR_W{1'b0}});
    rs2_zero_s     = (rs2_r == {ADDR_W{1'b0}});
`else
    write_needed_s = we_r;
    rs1_zero_s     = 1'b0;
    rs2_zero_s     = 1'b0;
`endif
  end

  // Next state and the port values for the state being entered (port outputs are registered).
  always_comb begin
    state_s    = state_r;
    rf_addr_s  = {ADDR_W{1'b0}};
    rf_wdata_s = {DATA_W{1'b0}};
    rf_write_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s   = RD1;
          rf_addr_s = req_rs1;
        end else begin
          state_s = IDLE;
        end
      end
      RD1: begin
        state_s   = RD2;
        rf_addr_s = rs2_r;
      end
      RD2: begin
        if (write_needed_s) begin
          state_s    = WR;
          rf_addr_s  = rd_r;
          rf_wdata_s = wdata_r;
          rf_write_s = 1'b1;
        end else begin
          state_s = RESP;
        end
      end
      WR: begin
        state_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and registered control/port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rf_addr_r   <= {ADDR_W{1'b0}};
      rf_wdata_r  <= {DATA_W{1'b0}};
      rf_write_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESP);
      rf_addr_r   <= rf_addr_s;
      rf_wdata_r  <= rf_wdata_s;
      rf_write_r  <= rf_write_s;
    end
  end

  // Request capture on the handshake edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_r   <= {ADDR_W{1'b0}};
      rs2_r   <= {ADDR_W{1'b0}};
      rd_r    <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
    end else if (state_r == IDLE && req_valid) begin
      rs1_r   <= req_rs1;
      rs2_r   <= req_rs2;
      rd_r    <= req_rd;
      wdata_r <= req_wdata;
      we_r    <= req_we;
    end
  end

  // Operand capture; rf_addr already points at the source register during RD1/RD2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op1_r <= {DATA_W{1'b0}};
      op2_r <= {DATA_W{1'b0}};
    end else if (state_r == RD1) begin
      op1_r <= rs1_zero_s ? {DATA_W{1'b0}} : rf_rdata;
    end else if (state_r == RD2) begin
      op2_r <= rs2_zero_s ? {DATA_W{1'b0}} : rf_rdata;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_op1   = op1_r;
  assign rsp_op2   = op2_r;
  assign rf_addr   = rf_addr_r;
  assign rf_wdata  = rf_wdata_r;
  assign rf_write  = rf_write_r;

endmodule

// File: tb/tb_reg_file_seq.sv
// Self-checking bench for reg_file_seq: table of request vectors plus hand sequences for backpressure and mid-write reset.
module tb_reg_file_seq;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1 = '0;
  logic [ADDR_W-1:0] req_rs2 = '0;
  logic [ADDR_W-1:0] req_rd = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_we = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_op1;
  logic [DATA_W-1:0] rsp_op2;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_write;
  logic [DATA_W-1:0] rf_rdata;

  logic [DATA_W-1:0] mem [0:31];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_wa = '0;
  logic [DATA_W-1:0] last_wd = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] exp_op1;
    logic [DATA_W-1:0] exp_op2;
    int                exp_lat;
    int                exp_writes;
  } vec_t;

  vec_t vecs [7];

  reg_file_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op1   (rsp_op1),
    .rsp_op2   (rsp_op2),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_write  (rf_write),
    .rf_rdata  (rf_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata = mem[rf_addr];

  // Register file model: bench preload port plus the DUT write port.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    if (rf_write) begin
      mem[rf_addr] <= rf_wdata;
      wr_cnt       <= wr_cnt + 1;
      last_wa      <= rf_addr;
      last_wd      <= rf_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Issue one request (DUT must be idle) and return the edge count until rsp_valid, handshake edge counted as 1.
  task automatic issue(input vec_t v, output int lat);
    req_rs1   = v.rs1;
    req_rs2   = v.rs2;
    req_rd    = v.rd;
    req_wdata = v.wdata;
    req_we    = v.we;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_wdata = 16'h0000;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int w0;
    int bad;
    vec_t v;

    vecs[0] = '{5'd3, 5'd7, 5'd0, 16'h0000, 1'b0, 16'h1111, 16'h2222, 3, 0};
    vecs[1] = '{5'd5, 5'd6, 5'd9, 16'hBEEF, 1'b1, 16'h00AA, 16'h00BB, 4, 1};
    vecs[2] = '{5'd9, 5'd3, 5'd0, 16'h0000, 1'b0, 16'hBEEF, 16'h1111, 3, 0};
    vecs[3] = '{5'd4, 5'd4, 5'd4, 16'hFFFF, 1'b1, 16'h0004, 16'h0004, 4, 1};
    vecs[4] = '{5'd4, 5'd7, 5'd0, 16'h0000, 1'b0, 16'hFFFF, 16'h2222, 3, 0};
`ifdef RF_ZERO_REG_EN
    vecs[5] = '{5'd0, 5'd0, 5'd0, 16'h5555, 1'b1, 16'h0000, 16'h0000, 3, 0};
    vecs[6] = '{5'd0, 5'd3, 5'd0, 16'h0000, 1'b0, 16'h0000, 16'h1111, 3, 0};
`else
    vecs[5] = '{5'd0, 5'd0, 5'd0, 16'h5555, 1'b1, 16'h1234, 16'h1234, 4, 1};
    vecs[6] = '{5'd0, 5'd3, 5'd0, 16'h0000, 1'b0, 16'h5555, 16'h1111, 3, 0};
`endif

    rst = 1'b0;
    tick();
    tick();
    check("rst_rf_write", {31'd0, rf_write}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_ops", {rsp_op1, rsp_op2}, 32'd0);
    check("rst_rf_port", {11'd0, rf_addr, rf_wdata}, 32'd0);

    preload(5'd3, 16'h1111);
    preload(5'd7, 16'h2222);
    preload(5'd5, 16'h00AA);
    preload(5'd6, 16'h00BB);
    preload(5'd4, 16'h0004);
    preload(5'd0, 16'h1234);
    tick();

    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v  = vecs[i];
      w0 = wr_cnt;
      issue(v, lat);
      check($sformatf("v%0d_latency", i), lat, v.exp_lat);
      check($sformatf("v%0d_op1", i), {16'd0, rsp_op1}, {16'd0, v.exp_op1});
      check($sformatf("v%0d_op2", i), {16'd0, rsp_op2}, {16'd0, v.exp_op2});
      check($sformatf("v%0d_writes", i), wr_cnt - w0, v.exp_writes);
      if (v.exp_writes == 1) begin
        check($sformatf("v%0d_wr_addr", i), {27'd0, last_wa}, {27'd0, v.rd});
        check($sformatf("v%0d_wr_data", i), {16'd0, last_wd}, {16'd0, v.wdata});
      end
      tick();
      check($sformatf("v%0d_back_idle", i), {30'd0, req_ready, rsp_valid}, 32'd2);
      check($sformatf("v%0d_idle_port", i), {11'd0, rf_addr, rf_wdata}, 32'd0);
    end

    // Backpressure: response held for 10 cycles with no register-file activity.
    rsp_ready = 1'b0;
    w0 = wr_cnt;
    v  = '{5'd3, 5'd7, 5'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 0};
    issue(v, lat);
    check("bp_latency", lat, 3);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rf_write !== 1'b0 ||
          rsp_op1 !== 16'h1111 || rsp_op2 !== 16'h2222) begin
        bad++;
      end
    end
    check("bp_hold_bad_cycles", bad, 0);
    check("bp_no_write", wr_cnt - w0, 0);
    rsp_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset asserted while the write to reg 7 is on the port.
    w0 = wr_cnt;
    v  = '{5'd3, 5'd7, 5'd7, 16'hDEAD, 1'b1, 16'h0000, 16'h0000, 0, 0};
    req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd = v.rd; req_wdata = v.wdata; req_we = v.we;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("wr_state_write", {31'd0, rf_write}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_write_drop", {31'd0, rf_write}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_no_write", wr_cnt - w0, 0);
    v = '{5'd7, 5'd9, 5'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 0};
    issue(v, lat);
    check("mid_rst_latency", lat, 3);
    check("mid_rst_reg7_kept", {16'd0, rsp_op1}, 32'h2222);
    check("mid_rst_reg9", {16'd0, rsp_op2}, 32'hBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
